// File: rtl/lives_bar_display.sv
// ============================================================================
//  Module   : lives_bar_display
//  Purpose  : Frame-synchronous heart-row HUD with a blink animation on lost lives.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module lives_bar_display #(
   parameter int MAX_LIVES    = 3,
   parameter int LW           = 4,
   parameter int SPACING      = 6,
   parameter int SPRITE_TABLE = 2,
   parameter int HEART_SPRITE = 31,
   parameter int BLANK_SPRITE = 0,
   parameter int BLINK_FRAMES = 16,
   parameter int BLINK_PERIOD = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          frame_tick,
   input  logic [LW-1:0] lives,
   input  logic [8:0]    X,
   input  logic [8:0]    Y,
   input  logic [8:0]    H_pos,
   input  logic [8:0]    V_pos,
   output logic          lives_s,
   output logic          anim_busy
);

   localparam int             FW     = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [FW-1:0]  F_LAST = FW'(BLINK_FRAMES - 1);
   localparam int             SPR_W  = 5;
   localparam int             SPR_H  = 5;
   localparam logic [0:0]     S_IDLE  = 1'b0;
   localparam logic [0:0]     S_BLINK = 1'b1;

   logic [0:0]           state, state_n;
   logic [LW-1:0]        shown, shown_n;
   logic [LW-1:0]        lost_lo, lost_lo_n;
   logic [LW-1:0]        lost_hi, lost_hi_n;
   logic [FW-1:0]        fcnt, fcnt_n;
   logic [MAX_LIVES-1:0] sel, sel_n;
   logic [MAX_LIVES-1:0] pix;
   logic [LW-1:0]        lv;
   logic                 blink_on;

   function automatic logic blink_phase(input logic [FW-1:0] f);
      int q;
      q = int'(f) / BLINK_PERIOD;
      return (q % 2) == 0;
   endfunction

   // Sprite ROM: the heart glyph lives at entry 31 of table 2; every other entry is empty.
   function automatic logic [4:0] glyph_row(input logic [4:0] spr, input logic [2:0] r);
      logic [4:0] bits;
      bits = 5'b00000;
      if (SPRITE_TABLE == 2 && spr == 5'd31) begin
         case (r)
            3'd0:    bits = 5'b01010;
            3'd1:    bits = 5'b11111;
            3'd2:    bits = 5'b11111;
            3'd3:    bits = 5'b01110;
            3'd4:    bits = 5'b00100;
            default: bits = 5'b00000;
         endcase
      end
      return bits;
   endfunction

   assign lv        = (lives > LW'(MAX_LIVES)) ? LW'(MAX_LIVES) : lives;
   assign anim_busy = (state == S_BLINK);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         shown   <= '0;
         lost_lo <= '0;
         lost_hi <= '0;
         fcnt    <= '0;
         sel     <= '0;
      end else begin
         state   <= state_n;
         shown   <= shown_n;
         lost_lo <= lost_lo_n;
         lost_hi <= lost_hi_n;
         fcnt    <= fcnt_n;
         sel     <= sel_n;
      end
   end

   always_comb begin
      state_n   = state;
      shown_n   = shown;
      lost_lo_n = lost_lo;
      lost_hi_n = lost_hi;
      fcnt_n    = fcnt;
      if (frame_tick) begin
         case (state)
            S_IDLE: begin
               if (lv < shown) begin
                  lost_lo_n = lv;
                  lost_hi_n = shown;
                  shown_n   = lv;
                  fcnt_n    = '0;
                  state_n   = S_BLINK;
               end else if (lv > shown) begin
                  shown_n = lv;
               end
            end
            default: begin
               if (lv < shown) begin
                  lost_lo_n = lv;
                  shown_n   = lv;
                  fcnt_n    = '0;
               end else if (lv > shown && lv >= lost_hi) begin
                  shown_n   = lv;
                  lost_lo_n = '0;
                  lost_hi_n = '0;
                  fcnt_n    = '0;
                  state_n   = S_IDLE;
               end else if (lv > shown) begin
                  // Partial regain: the still-lost tail keeps blinking on the same timeline.
                  shown_n   = lv;
                  lost_lo_n = lv;
               end else if (fcnt == F_LAST) begin
                  lost_lo_n = '0;
                  lost_hi_n = '0;
                  fcnt_n    = '0;
                  state_n   = S_IDLE;
               end else begin
                  fcnt_n = fcnt + 1'b1;
               end
            end
         endcase
      end
   end

   // Slot selects are built from next-state values so they change on the same edge as the FSM.
   always_comb begin
      blink_on = blink_phase(fcnt_n);
      sel_n    = '0;
      for (int i = 0; i < MAX_LIVES; i++) begin
         sel_n[i] = (LW'(i) < shown_n) ||
                    ((state_n == S_BLINK) && (LW'(i) >= lost_lo_n) &&
                     (LW'(i) < lost_hi_n) && blink_on);
      end
   end

   for (genvar i = 0; i < MAX_LIVES; i++) begin : g_slot
      localparam logic [8:0] OFF = 9'((i * SPACING) % 512);
      logic [8:0] ox;
      logic [8:0] dx;
      logic [8:0] dy;
      logic [4:0] spr;
      logic [4:0] row;
      assign ox     = X + OFF;
      assign dx     = H_pos - ox;
      assign dy     = V_pos - Y;
      assign spr    = sel[i] ? 5'(HEART_SPRITE) : 5'(BLANK_SPRITE);
      assign row    = glyph_row(spr, dy[2:0]);
      assign pix[i] = (dx < 9'(SPR_W)) && (dy < 9'(SPR_H)) && row[3'(SPR_W - 1) - dx[2:0]];
   end

   assign lives_s = |pix;

endmodule

`default_nettype wire

// File: tb/tb_lives_bar_display.sv
// ============================================================================
//  Module   : tb_lives_bar_display
//  Purpose  : Self-checking bench for lives_bar_display (vectors + random vs. model).
//  Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/100ps

module tb_lives_bar_display;

   localparam int ML = 5;
   localparam int LWB = 3;
   localparam int SP = 6;
   localparam int BF = 8;
   localparam int BP = 2;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           frame_tick;
   logic [LWB-1:0] lives;
   logic [8:0]     X, Y, H_pos, V_pos;
   logic           lives_s;
   logic           anim_busy;

   lives_bar_display #(
      .MAX_LIVES(ML), .LW(LWB), .SPACING(SP), .SPRITE_TABLE(2),
      .HEART_SPRITE(31), .BLANK_SPRITE(0), .BLINK_FRAMES(BF), .BLINK_PERIOD(BP)
   ) dut (
      .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .lives(lives),
      .X(X), .Y(Y), .H_pos(H_pos), .V_pos(V_pos),
      .lives_s(lives_s), .anim_busy(anim_busy)
   );

   always #10 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference state: what the HUD should show, in plain integers.
   int m_shown, m_lo, m_hi, m_f;
   bit m_blink;
   int heart [5] = '{10, 31, 31, 14, 4};

   typedef struct {
      int lives;
      int slots;
      bit busy;
   } vec_t;
   vec_t tv [11];

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic m_reset();
      m_shown = 0; m_lo = 0; m_hi = 0; m_f = 0; m_blink = 0;
   endtask

   task automatic m_tick(input int raw);
      int lv;
      lv = (raw > ML) ? ML : raw;
      if (!m_blink) begin
         if (lv < m_shown) begin
            m_lo = lv; m_hi = m_shown; m_shown = lv; m_f = 0; m_blink = 1;
         end else if (lv > m_shown) begin
            m_shown = lv;
         end
      end else begin
         if (lv < m_shown) begin
            m_lo = lv; m_shown = lv; m_f = 0;
         end else if (lv > m_shown && lv >= m_hi) begin
            m_shown = lv; m_lo = 0; m_hi = 0; m_f = 0; m_blink = 0;
         end else if (lv > m_shown) begin
            m_shown = lv; m_lo = lv;
         end else if (m_f == BF - 1) begin
            m_lo = 0; m_hi = 0; m_f = 0; m_blink = 0;
         end else begin
            m_f++;
         end
      end
   endtask

   function automatic bit m_slot_on(input int i);
      return (i < m_shown) ||
             (m_blink && i >= m_lo && i < m_hi && ((m_f / BP) % 2 == 0));
   endfunction

   function automatic int m_slots();
      int v = 0;
      for (int i = 0; i < ML; i++) if (m_slot_on(i)) v |= (1 << i);
      return v;
   endfunction

   function automatic bit m_pixel(input int h, input int v);
      int dx, dy;
      bit hit = 0;
      dy = (v - int'(Y) + 512) % 512;
      for (int i = 0; i < ML; i++) begin
         dx = (h - ((int'(X) + i * SP) % 512) + 1024) % 512;
         if (m_slot_on(i) && dx < 5 && dy < 5 && (((heart[dy] >> (4 - dx)) & 1) == 1))
            hit = 1;
      end
      return hit;
   endfunction

   task automatic step(input bit tick, input int lv);
      lives      = 3'(lv);
      frame_tick = tick;
      @(posedge clk);
      #1;
      frame_tick = 1'b0;
      if (tick) m_tick(lv);
   endtask

   // Probes the centre pixel of every slot; bit i set when slot i draws there.
   task automatic probe_slots(output int v);
      v = 0;
      for (int i = 0; i < ML; i++) begin
         H_pos = 9'((int'(X) + i * SP + 2) % 512);
         V_pos = Y + 9'd2;
         #1;
         if (lives_s) v |= (1 << i);
      end
   endtask

   task automatic check_slots(input string name, input int exp_slots, input int exp_busy);
      int v;
      probe_slots(v);
      check({name, " slots"}, v, exp_slots);
      check({name, " busy"}, int'(anim_busy), exp_busy);
   endtask

   task automatic check_model(input string name);
      check_slots(name, m_slots(), int'(m_blink));
   endtask

   initial begin
      tv[0]  = '{3, 5'b00111, 1'b0};
      tv[1]  = '{1, 5'b00111, 1'b1};
      tv[2]  = '{1, 5'b00111, 1'b1};
      tv[3]  = '{1, 5'b00001, 1'b1};
      tv[4]  = '{1, 5'b00001, 1'b1};
      tv[5]  = '{1, 5'b00111, 1'b1};
      tv[6]  = '{1, 5'b00111, 1'b1};
      tv[7]  = '{1, 5'b00001, 1'b1};
      tv[8]  = '{1, 5'b00001, 1'b1};
      tv[9]  = '{1, 5'b00001, 1'b0};
      tv[10] = '{7, 5'b11111, 1'b0};

      rst_n = 1'b0; frame_tick = 1'b0; lives = '0;
      X = 9'd100; Y = 9'd20; H_pos = '0; V_pos = '0;
      m_reset();
      repeat (3) @(posedge clk);
      #1;
      check_slots("reset", 0, 0);
      rst_n = 1'b1;

      // Without ticks nothing is sampled.
      repeat (3) step(1'b0, 3);
      check_slots("no_tick", 0, 0);

      for (int k = 0; k < 11; k++) begin
         step(1'b1, tv[k].lives);
         check_slots($sformatf("vec%0d", k), tv[k].slots, int'(tv[k].busy));
      end

      // Further loss mid-animation restarts the blink.
      step(1'b1, 3);
      repeat (4) step(1'b1, 3);
      check_model("t3_pre");
      step(1'b1, 2);
      check_slots("t3_restart", 5'b11111, 1);
      for (int t = 1; t <= 8; t++) begin
         step(1'b1, 2);
         check($sformatf("t3_busy%0d", t), int'(anim_busy), (t < 8) ? 1 : 0);
      end
      check_slots("t3_end", 5'b00011, 0);

      // Full regain cancels; partial regain keeps the tail blinking.
      step(1'b1, 4);
      step(1'b1, 1);
      step(1'b1, 4);
      check_slots("t4_regain", 5'b01111, 0);
      step(1'b1, 1);
      step(1'b1, 1);
      step(1'b1, 2);
      check_slots("t4_partial", 5'b01111, 1);
      step(1'b1, 2);
      check_slots("t4_phase", 5'b00011, 1);
      for (int t = 0; t < 8; t++) begin
         step(1'b1, 2);
         check_model($sformatf("t4_run%0d", t));
      end

      // Clamp and x wrap.
      step(1'b1, 7);
      check_slots("t5_clamp", 5'b11111, 0);
      X = 9'd500; V_pos = 9'd22;
      H_pos = 9'd2;   #1; check("t5_wrap_slot2", int'(lives_s), 1);
      H_pos = 9'd508; #1; check("t5_slot1", int'(lives_s), 1);
      H_pos = 9'd5;   #1; check("t5_gap", int'(lives_s), 0);
      X = 9'd100;

      // Reset in the middle of a blink.
      step(1'b1, 1);
      repeat (3) step(1'b1, 1);
      H_pos = 9'd102; V_pos = 9'd22; #1;
      check("t6_before", int'(lives_s), 1);
      rst_n = 1'b0;
      #1;
      check("t6_rst_pix", int'(lives_s), 0);
      check("t6_rst_busy", int'(anim_busy), 0);
      m_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (2) step(1'b0, 4);
      check_slots("t6_after", 0, 0);
      step(1'b1, 3);
      check_slots("t6_tick", 5'b00111, 0);

      // Random ticks and lives against the model.
      for (int n = 0; n < 300; n++) begin
         step($urandom_range(0, 3) != 0, int'($urandom_range(0, 7)));
         check_model($sformatf("rnd%0d", n));
         H_pos = 9'($urandom_range(95, 135));
         V_pos = 9'($urandom_range(18, 26));
         #1;
         check($sformatf("rnd_pix%0d", n), int'(lives_s),
               int'(m_pixel(int'(H_pos), int'(V_pos))));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
